req_queue: RTL and testbench

REQ_QUEUE -- requirements
Module: req_queue

---
 rtl/req_queue.sv | 123 ++++++++++++
 tb/tb_req_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/req_queue.sv
// Request router feeding two independent first-word-fall-through FIFOs (AES / SHA).
// Define REQ_QUEUE_FULL_PUSHPOP_EN to accept a push into a full queue when it pops that cycle.
module req_queue_fifo #(
    parameter int W      = 18,
    parameter int QDEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_req,
    input  logic [W-1:0] wdata,
    output logic         ready_in,
    output logic         valid_out,
    output logic [W-1:0] rdata,
    input  logic         ready_out
);
    localparam int AW = $clog2(QDEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem_q [QDEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [W-1:0]  head_q, head_d;
    logic          empty, full, push, pop;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = !empty && ready_out;

`ifdef REQ_QUEUE_FULL_PUSHPOP_EN
    assign ready_in = !full || pop;
`else
    assign ready_in = !full;
`endif

    assign push      = push_req && ready_in;
    assign valid_out = !empty;
    assign rdata     = head_q;

    // Head register holds the next-cycle oldest entry; bypass when it is being written now.
    always_comb begin
        wptr_d = wptr_q + PW'(push);
        rptr_d = rptr_q + PW'(pop);
        head_d = head_q;
        if (rptr_d != wptr_d) begin
            if (push && (rptr_d == wptr_q)) begin
                head_d = wdata;
            end else begin
                head_d = mem_q[rptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            head_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end
endmodule

module req_queue #(
    parameter int ADDRW   = 8,
    parameter int OPCODEW = 2,
    parameter int QDEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_in,
    input  logic [OPCODEW-1:0]         opcode,
    input  logic [ADDRW-1:0]           key_addr,
    input  logic [ADDRW-1:0]           text_addr,
    output logic                       ready_in_aes,
    output logic                       ready_in_sha,
    output logic [2*ADDRW+OPCODEW-1:0] instr_aes,
    output logic                       valid_out_aes,
    input  logic                       ready_out_aes,
    output logic [2*ADDRW+OPCODEW-1:0] instr_sha,
    output logic                       valid_out_sha,
    input  logic                       ready_out_sha
);
    localparam int IW = 2 * ADDRW + OPCODEW;

    logic [IW-1:0] req_word;
    logic          to_sha;

    // rst_n is active-high despite its name.
    assign req_word = {opcode, key_addr, text_addr};
    assign to_sha   = opcode[OPCODEW-1];

    req_queue_fifo #(.W(IW), .QDEPTH(QDEPTH)) u_aes (
        .clk       (clk),
        .rst       (rst_n),
        .push_req  (valid_in && !to_sha),
        .wdata     (req_word),
        .ready_in  (ready_in_aes),
        .valid_out (valid_out_aes),
        .rdata     (instr_aes),
        .ready_out (ready_out_aes)
    );

    req_queue_fifo #(.W(IW), .QDEPTH(QDEPTH)) u_sha (
        .clk       (clk),
        .rst       (rst_n),
        .push_req  (valid_in && to_sha),
        .wdata     (req_word),
        .ready_in  (ready_in_sha),
        .valid_out (valid_out_sha),
        .rdata     (instr_sha),
        .ready_out (ready_out_sha)
    );
endmodule

// File: tb/tb_req_queue.sv
// Randomised + directed bench for req_queue against a queue-based reference model.
// Honours REQ_QUEUE_FULL_PUSHPOP_EN when the design is built with it.
module tb_req_queue;
    localparam int ADDRW   = 8;
    localparam int OPCODEW = 2;
    localparam int QDEPTH  = 16;
    localparam int IW      = 2 * ADDRW + OPCODEW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              valid_in = 1'b0;
    logic [OPCODEW-1:0] opcode = '0;
    logic [ADDRW-1:0]  key_addr = '0;
    logic [ADDRW-1:0]  text_addr = '0;
    logic              ready_in_aes, ready_in_sha;
    logic [IW-1:0]     instr_aes, instr_sha;
    logic              valid_out_aes, valid_out_sha;
    logic              ready_out_aes = 1'b0;
    logic              ready_out_sha = 1'b0;

    req_queue #(.ADDRW(ADDRW), .OPCODEW(OPCODEW), .QDEPTH(QDEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_in      (valid_in),
        .opcode        (opcode),
        .key_addr      (key_addr),
        .text_addr     (text_addr),
        .ready_in_aes  (ready_in_aes),
        .ready_in_sha  (ready_in_sha),
        .instr_aes     (instr_aes),
        .valid_out_aes (valid_out_aes),
        .ready_out_aes (ready_out_aes),
        .instr_sha     (instr_sha),
        .valid_out_sha (valid_out_sha),
        .ready_out_sha (ready_out_sha)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] mq_aes[$];
    logic [IW-1:0] mq_sha[$];
    logic [IW-1:0] last_aes = '0;
    logic [IW-1:0] last_sha = '0;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_ready(int sz, bit vo, bit ro);
`ifdef REQ_QUEUE_FULL_PUSHPOP_EN
        return (sz < QDEPTH) || (vo && ro);
`else
        return sz < QDEPTH;
`endif
    endfunction

    task automatic drive(bit v, logic [1:0] op, logic [7:0] k, logic [7:0] t,
                         bit ra, bit rs);
        valid_in      = v;
        opcode        = op;
        key_addr      = k;
        text_addr     = t;
        ready_out_aes = ra;
        ready_out_sha = rs;
    endtask

    // One clock: compare against the model at negedge, advance the model, return after posedge.
    task automatic step();
        bit e_va, e_vs, e_ra, e_rs;
        logic [IW-1:0] w;
        @(negedge clk);
        e_va = mq_aes.size() != 0;
        e_vs = mq_sha.size() != 0;
        if (e_va) last_aes = mq_aes[0];
        if (e_vs) last_sha = mq_sha[0];
        e_ra = exp_ready(mq_aes.size(), e_va, ready_out_aes);
        e_rs = exp_ready(mq_sha.size(), e_vs, ready_out_sha);
        check("valid_out_aes", 32'(valid_out_aes), 32'(e_va));
        check("valid_out_sha", 32'(valid_out_sha), 32'(e_vs));
        check("instr_aes", 32'(instr_aes), 32'(last_aes));
        check("instr_sha", 32'(instr_sha), 32'(last_sha));
        check("ready_in_aes", 32'(ready_in_aes), 32'(e_ra));
        check("ready_in_sha", 32'(ready_in_sha), 32'(e_rs));
        if (rst_n) begin
            mq_aes.delete();
            mq_sha.delete();
            last_aes = '0;
            last_sha = '0;
        end else begin
            if (e_va && ready_out_aes) void'(mq_aes.pop_front());
            if (e_vs && ready_out_sha) void'(mq_sha.pop_front());
            w = {opcode, key_addr, text_addr};
            if (valid_in) begin
                if (opcode[1]) begin
                    if (e_rs) mq_sha.push_back(w);
                end else begin
                    if (e_ra) mq_aes.push_back(w);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        rst_n = 1'b0;
        check("rst_valid_aes", 32'(valid_out_aes), 32'd0);
        check("rst_instr_aes", 32'(instr_aes), 32'd0);
        check("rst_ready_sha", 32'(ready_in_sha), 32'd1);

        // AES routing
        drive(1, 2'b00, 8'h12, 8'h34, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        check("aes_route_valid", 32'(valid_out_aes), 32'd1);
        check("aes_route_instr", 32'(instr_aes), 32'h01234);
        check("aes_route_sha_idle", 32'(valid_out_sha), 32'd0);

        // SHA routing and pop
        drive(1, 2'b10, 8'hAB, 8'hCD, 0, 0);
        step();
        drive(0, 0, 0, 0, 1, 1);
        check("sha_route_instr", 32'(instr_sha), 32'h2ABCD);
        check("sha_route_valid", 32'(valid_out_sha), 32'd1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        check("sha_pop_valid", 32'(valid_out_sha), 32'd0);
        check("sha_pop_hold", 32'(instr_sha), 32'h2ABCD);
        step();

        // Fill AES to capacity, overflow push, then drain in order
        for (int i = 0; i < QDEPTH; i++) begin
            drive(1, 2'b01, 8'(i), 8'(8'hA0 + i), 0, 0);
            step();
        end
        check("full_ready_aes", 32'(ready_in_aes), 32'd0);
        check("full_ready_sha", 32'(ready_in_sha), 32'd1);
        drive(1, 2'b00, 8'hFF, 8'hFF, 0, 0);
        step();
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < QDEPTH; i++) begin
            check("drain_order", 32'(instr_aes),
                  32'({2'b01, 8'(i), 8'(8'hA0 + i)}));
            step();
        end
        check("drain_empty", 32'(valid_out_aes), 32'd0);

        // Back-pressure with three entries queued
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b00, 8'(8'h50 + i), 8'h77, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_instr", 32'(instr_aes), 32'({2'b00, 8'h50, 8'h77}));
            check("bp_valid", 32'(valid_out_aes), 32'd1);
            step();
        end

        // Reset with both queues non-empty
        drive(1, 2'b11, 8'h33, 8'h44, 0, 0);
        step();
        rst_n = 1'b1;
        drive(1, 2'b00, 8'h99, 8'h99, 1, 1);
        step();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        check("rst_mid_valid_aes", 32'(valid_out_aes), 32'd0);
        check("rst_mid_valid_sha", 32'(valid_out_sha), 32'd0);
        check("rst_mid_ready_aes", 32'(ready_in_aes), 32'd1);
        check("rst_mid_ready_sha", 32'(ready_in_sha), 32'd1);

        // Interleaved push/pop on AES, wrapping pointers
        for (int i = 0; i < 40; i++) begin
            drive(1, 2'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                  bit'($urandom_range(0, 1)), 0);
            step();
        end
        drive(0, 0, 0, 0, 1, 0);
        repeat (QDEPTH + 2) step();

        // Mixed random traffic with varying back-pressure and rare resets
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 200; i++) begin
                rst_n = ($urandom_range(0, 149) == 0);
                drive(bit'($urandom_range(0, 3) != 0), 2'($urandom),
                      8'($urandom), 8'($urandom),
                      $urandom_range(0, 3) < ph,
                      $urandom_range(0, 3) < (3 - ph));
                step();
            end
        end
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 1, 1);
        repeat (QDEPTH + 2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
